shift_unit_pipe: RTL and testbench

//  Parametrised, pipelined shift unit generalising the fixed shift-left-by-2 used for branch offsets.

---
 rtl/shift_unit_pipe.sv | 131 +++++++++++++
 tb/tb_shift_unit_pipe.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) with elastic valid/ready stages.
// One stage per shift layer when PIPE=1, otherwise a single output register.
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int PIPE = 1,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int N = (PIPE != 0) ? SHW : 1;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   sh;
    logic [1:0]       op;
    logic             sg;
    logic [TAG_W-1:0] tag;
  } stg_t;

  function automatic logic [WIDTH-1:0] layerShift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sg,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (op)
      2'b00:   r = d << amt;
      2'b01:   r = d >> amt;
      2'b10:   r = (d >> amt) | ({WIDTH{sg}} << (WIDTH - amt));
      default: r = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return r;
  endfunction

  // Applies layers lo..hi; each layer j shifts by 2^j when shamt bit j is set.
  function automatic stg_t applyLayers(
    input stg_t s,
    input int   lo,
    input int   hi
  );
    stg_t r;
    r = s;
    for (int j = 0; j < SHW; j++) begin
      if (j >= lo && j <= hi && s.sh[j]) begin
        r.d = layerShift(r.d, s.op, s.sg, 1 << j);
      end
    end
    return r;
  endfunction

  stg_t [N-1:0] stg;
  stg_t [N-1:0] feed;
  stg_t [N-1:0] nxt;
  logic [N-1:0] vld;
  logic [N-1:0] feedV;
  logic [N-1:0] load;
  logic         zeroQ;
  logic         inFire;
  logic         unusedBits;

  assign in_ready = load[0] & ~flush & ~reset;
  assign inFire = in_valid & in_ready;

  assign feed[0] = '{
    d:   in_data,
    sh:  in_shamt,
    op:  in_op,
    sg:  in_data[WIDTH-1],
    tag: in_tag
  };
  assign feedV[0] = inFire;

  // A stage can load unless it and every stage after it is full and stalled.
  for (genvar k = 0; k < N; k++) begin : gStage
    localparam int LO = (PIPE != 0) ? k : 0;
    localparam int HI = (PIPE != 0) ? k : SHW - 1;
    assign load[k] = out_ready | ~(&vld[N-1:k]);
    assign nxt[k] = applyLayers(feed[k], LO, HI);
    if (k > 0) begin : gFeed
      assign feed[k] = stg[k-1];
      assign feedV[k] = vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      stg <= '0;
      zeroQ <= 1'b1;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          vld[k] <= feedV[k];
          if (feedV[k]) begin
            stg[k] <= nxt[k];
          end
        end
      end
      if (load[N-1] && feedV[N-1]) begin
        zeroQ <= (nxt[N-1].d == '0);
      end
    end
  end

  assign out_valid = vld[N-1];
  assign out_data = stg[N-1].d;
  assign out_tag = stg[N-1].tag;
  assign out_zero = zeroQ;

  assign unusedBits = ^{stg[N-1].sh, stg[N-1].op, stg[N-1].sg};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe.
// Drives a PIPE=0 and a PIPE=1 instance; unit 0 = PIPE=0, unit 1 = PIPE=1.
module tb_shift_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [1:0] inValid = '0;
  logic [1:0] inReady;
  logic [1:0] outValid;
  logic [1:0] outReady = '0;
  logic [1:0] outZero;
  logic [1:0][31:0] inData = '0;
  logic [1:0][31:0] outData;
  logic [1:0][4:0] inShamt = '0;
  logic [1:0][4:0] inTag = '0;
  logic [1:0][4:0] outTag;
  logic [1:0][1:0] inOp = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(32), .TAG_W(5), .PIPE(0)) dutC (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_data(inData[0]), .in_shamt(inShamt[0]),
    .in_op(inOp[0]), .in_tag(inTag[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .out_tag(outTag[0]),
    .out_zero(outZero[0])
  );

  shift_unit_pipe #(.WIDTH(32), .TAG_W(5), .PIPE(1)) dutP (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_data(inData[1]), .in_shamt(inShamt[1]),
    .in_op(inOp[1]), .in_tag(inTag[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .out_tag(outTag[1]),
    .out_zero(outZero[1])
  );

  function automatic int nStg(input int u);
    return (u == 1) ? 5 : 1;
  endfunction

  function automatic logic [31:0] refShift(
    input logic [31:0] d, input logic [1:0] op, input int sh);
    logic [31:0] r;
    case (op)
      2'd0: r = d << sh;
      2'd1: r = d >> sh;
      2'd2: r = $signed(d) >>> sh;
      default: r = (d >> sh) | (d << (32 - sh));
    endcase
    return r;
  endfunction

  task automatic doReset;
    rst = 1'b1;
    flush = 1'b0;
    inValid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pushOp(input int u, input logic [1:0] op,
    input logic [31:0] d, input logic [4:0] sh, input logic [4:0] tag);
    inOp[u] = op;
    inData[u] = d;
    inShamt[u] = sh;
    inTag[u] = tag;
    inValid[u] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (inReady[u]) begin
        @(posedge clk);
        #1;
        inValid[u] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL push_timeout unit %0d in_ready=%b required 1", u, inReady[u]);
    inValid[u] = 1'b0;
  endtask

  task automatic waitOut(input int u, output logic [31:0] d,
    output logic [4:0] t, output logic z, output int lat);
    lat = 1;
    d = '0;
    t = '0;
    z = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (outValid[u]) begin
        d = outData[u];
        t = outTag[u];
        z = outZero[u];
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    outReady = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (outValid[u] !== 1'b0 || outData[u] !== 32'h0 ||
          outTag[u] !== 5'h0 || outZero[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state unit %0d v=%b d=%h t=%h z=%b required 0/0/0/1",
          u, outValid[u], outData[u], outTag[u], outZero[u]);
      end
    end
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (inReady[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready unit %0d got %b required 1", u, inReady[u]);
      end
    end
  endtask

  task automatic test_sll;
    logic [31:0] d;
    logic [4:0] t;
    logic z;
    int lat;
    for (int u = 0; u < 2; u++) begin
      doReset();
      outReady[u] = 1'b1;
      pushOp(u, 2'd0, 32'h1, 5'd2, 5'd7);
      waitOut(u, d, t, z, lat);
      checks++;
      if (d !== 32'h4 || t !== 5'd7 || z !== 1'b0) begin
        errors++;
        $display("FAIL sll_basic unit %0d d=%h t=%0d z=%b required 4/7/0", u, d, t, z);
      end
      checks++;
      if (lat !== nStg(u)) begin
        errors++;
        $display("FAIL sll_latency unit %0d got %0d required %0d", u, lat, nStg(u));
      end
    end
  endtask

  task automatic test_edges;
    logic [1:0] cOp [10] = '{2, 1, 1, 3, 0, 1, 2, 3, 2, 0};
    logic [31:0] cD [10] = '{32'h80000000, 32'h80000000, 32'h1, 32'h12345678,
      32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F,
      32'h7FFFFFF0, 32'h80000001};
    logic [4:0] cSh [10] = '{31, 31, 1, 8, 0, 0, 0, 0, 4, 31};
    logic [31:0] cE [10] = '{32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h78123456,
      32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F,
      32'h07FFFFFF, 32'h80000000};
    logic [31:0] d;
    logic [4:0] t;
    logic z;
    int lat;
    for (int u = 0; u < 2; u++) begin
      doReset();
      outReady[u] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        pushOp(u, cOp[i], cD[i], cSh[i], 5'(i));
        waitOut(u, d, t, z, lat);
        checks++;
        if (d !== cE[i] || t !== 5'(i)) begin
          errors++;
          $display("FAIL edge_case %0d unit %0d d=%h t=%0d required %h/%0d",
            i, u, d, t, cE[i], i);
        end
        checks++;
        if (z !== (cE[i] == 32'h0)) begin
          errors++;
          $display("FAIL edge_zero %0d unit %0d got %b required %b",
            i, u, z, cE[i] == 32'h0);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expD [12];
    logic [4:0] expT [12];
    logic [1:0] op;
    int n;
    n = nStg(1);
    doReset();
    outReady[1] = 1'b1;
    for (int c = 0; c < 12 + n + 2; c++) begin
      if (c < 12) begin
        case (c % 3)
          0: op = 2'd0;
          1: op = 2'd3;
          default: op = 2'd2;
        endcase
        inOp[1] = op;
        inData[1] = $urandom;
        inShamt[1] = 5'($urandom_range(31));
        inTag[1] = 5'(c + 3);
        inValid[1] = 1'b1;
        expD[c] = refShift(inData[1], op, int'(inShamt[1]));
        expT[c] = 5'(c + 3);
      end else begin
        inValid[1] = 1'b0;
      end
      #1;
      if (c < 12) begin
        checks++;
        if (inReady[1] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cycle %0d got %b required 1", c, inReady[1]);
        end
      end
      checks++;
      if (outValid[1] !== (c >= n && c - n < 12)) begin
        errors++;
        $display("FAIL b2b_out_valid cycle %0d got %b required %b",
          c, outValid[1], c >= n && c - n < 12);
      end else if (c >= n && c - n < 12) begin
        checks++;
        if (outData[1] !== expD[c-n] || outTag[1] !== expT[c-n]) begin
          errors++;
          $display("FAIL b2b_result %0d d=%h t=%0d required %h/%0d",
            c - n, outData[1], outTag[1], expD[c-n], expT[c-n]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall;
    logic [31:0] expD [$];
    logic [4:0] expT [$];
    logic [31:0] d;
    int acc;
    acc = 0;
    doReset();
    outReady[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 8) begin
        inOp[1] = 2'($urandom_range(3));
        inData[1] = $urandom | 32'h1;
        inShamt[1] = 5'($urandom_range(3));
        inTag[1] = 5'(acc + 10);
        inValid[1] = 1'b1;
      end
      #1;
      if (inValid[1] && inReady[1]) begin
        d = refShift(inData[1], inOp[1], int'(inShamt[1]));
        expD.push_back(d);
        expT.push_back(5'(acc + 10));
        acc++;
      end
      if (outValid[1] && expD.size() > 0) begin
        checks++;
        if (outData[1] !== expD[0]) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got %h required %h", c, outData[1], expD[0]);
        end
      end
      @(posedge clk);
      #1;
    end
    inValid[1] = 1'b0;
    #1;
    checks++;
    if (acc !== 5 || inReady[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepts got %0d ready=%b required 5 ready=0", acc, inReady[1]);
    end
    outReady[1] = 1'b1;
    for (int i = 0; i < 5 && i < expD.size(); i++) begin
      #1;
      checks++;
      if (outValid[1] !== 1'b1 || outData[1] !== expD[i] || outTag[1] !== expT[i]) begin
        errors++;
        $display("FAIL stall_drain %0d v=%b d=%h t=%0d required 1/%h/%0d",
          i, outValid[1], outData[1], outTag[1], expD[i], expT[i]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (outValid[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty got %b required 0", outValid[1]);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    logic [4:0] t;
    logic z;
    int lat;
    bit seen;
    doReset();
    outReady[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      inOp[1] = 2'd0;
      inData[1] = 32'h10 << c;
      inShamt[1] = 5'd1;
      inTag[1] = 5'(c + 1);
      inValid[1] = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    inData[1] = 32'hDEAD;
    #1;
    checks++;
    if (inReady[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready got %b required 0", inReady[1]);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    inValid[1] = 1'b0;
    checks++;
    if (outValid[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_out_valid got %b required 0", outValid[1]);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (outValid[1]) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_leak got out_valid=1 required none");
    end
    pushOp(1, 2'd3, 32'h000000F1, 5'd4, 5'd21);
    waitOut(1, d, t, z, lat);
    checks++;
    if (d !== 32'h1000000F || t !== 5'd21 || lat !== 5) begin
      errors++;
      $display("FAIL flush_after d=%h t=%0d lat=%0d required 1000000f/21/5", d, t, lat);
    end
  endtask

  task automatic test_mid_reset;
    bit got;
    doReset();
    outReady[1] = 1'b0;
    pushOp(1, 2'd0, 32'hF0, 5'd1, 5'd3);
    pushOp(1, 2'd1, 32'hF0, 5'd2, 5'd4);
    pushOp(1, 2'd2, 32'h800000F0, 5'd3, 5'd5);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (outValid[1]) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!got || outData[1] !== 32'h1E0) begin
      errors++;
      $display("FAIL midreset_prefill v=%b d=%h required 1/1e0", got, outData[1]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (outValid[1] !== 1'b0 || outData[1] !== 32'h0 ||
        outZero[1] !== 1'b1 || outTag[1] !== 5'h0) begin
      errors++;
      $display("FAIL midreset_state v=%b d=%h z=%b t=%h required 0/0/1/0",
        outValid[1], outData[1], outZero[1], outTag[1]);
    end
  endtask

  task automatic sweep(input int u, input int cycles);
    logic [31:0] expD [$];
    logic [4:0] expT [$];
    logic [31:0] held;
    logic [31:0] e;
    bit holding;
    bit pend;
    holding = 1'b0;
    pend = 1'b0;
    outReady[u] = 1'b1;
    inValid[u] = 1'b0;
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      if (holding) begin
        checks++;
        if (outValid[u] !== 1'b1 || outData[u] !== held) begin
          errors++;
          $display("FAIL sweep_hold unit %0d v=%b d=%h required 1/%h",
            u, outValid[u], outData[u], held);
        end
      end
      holding = 1'b0;
      if (outValid[u] && outReady[u]) begin
        checks++;
        if (expD.size() == 0) begin
          errors++;
          $display("FAIL sweep_spurious unit %0d d=%h required no output", u, outData[u]);
        end else begin
          e = expD.pop_front();
          if (outData[u] !== e || outTag[u] !== expT[0] || outZero[u] !== (e == 0)) begin
            errors++;
            $display("FAIL sweep_result unit %0d d=%h t=%0d z=%b required %h/%0d/%b",
              u, outData[u], outTag[u], outZero[u], e, expT[0], e == 0);
          end
          void'(expT.pop_front());
        end
      end else if (outValid[u]) begin
        holding = 1'b1;
        held = outData[u];
      end
      if (inValid[u] && inReady[u]) begin
        expD.push_back(refShift(inData[u], inOp[u], int'(inShamt[u])));
        expT.push_back(inTag[u]);
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c >= cycles) begin
        if (!pend) inValid[u] = 1'b0;
        outReady[u] = 1'b1;
      end else begin
        if (!pend && $urandom_range(3) != 0) begin
          inOp[u] = 2'($urandom_range(3));
          inData[u] = ($urandom_range(5) == 0) ?
            (32'h1 << $urandom_range(31)) : $urandom;
          inShamt[u] = 5'($urandom_range(31));
          inTag[u] = 5'($urandom_range(31));
          inValid[u] = 1'b1;
          pend = 1'b1;
        end else if (!pend) begin
          inValid[u] = 1'b0;
        end
        outReady[u] = ($urandom_range(3) != 0);
      end
    end
    inValid[u] = 1'b0;
    checks++;
    if (expD.size() != 0 || pend) begin
      errors++;
      $display("FAIL sweep_leftover unit %0d got %0d pending required 0", u, expD.size());
    end
  endtask

  task automatic test_random;
    doReset();
    fork
      sweep(0, 600);
      sweep(1, 600);
    join
  endtask

  initial begin
    test_reset();
    test_sll();
    test_edges();
    test_back_to_back();
    test_stall();
    test_flush();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
